code_rom: RTL and testbench
===========================

Name: code_rom

Overview:
- 32-entry x 8-bit read-only program store holding the fixed instruction bytes of the TMD4 core.
- Sits between the fetch logic (address source) and the instruction decoder (code consumer).
- Contents are hard-wired in RTL as a constant lookup; no write path.
- Read is registered: one clock of latency, with an enable and an output-valid flag.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32 entries.
- DATA_W, 8, width of each stored code byte.
- FILL, 8'h00, value returned for every address not listed in the contents table.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on rising edge of clk.
- en  input  1  read enable; when high, addr is sampled this edge.
- addr  input  5  word address, 0..31.
- code  output  8  registered code byte read from addr.
- code_vld  output  1  high for the cycle(s) code holds data from an enabled read.

Behaviour:
- Contents, addresses 0..15, hex:
  - 0-3: 10 21 32 43
  - 4-7: 54 65 76 87
  - 8-11: 98 A9 BA CB
  - 12-15: DC ED FE 0F
- Contents rule: entry n (0..15) = {(n+1) mod 16, n} as high nibble and low nibble.
- Addresses 16..31 return FILL (8'h00).
- Reset:
  - On a rising edge with rst=1: code <= 8'h00 and code_vld <= 0, regardless of en and addr.
  - rst has priority over en.
- Read:
  - On a rising edge with rst=0 and en=1: code <= table[addr] and code_vld <= 1.
  - Latency is exactly 1 clock; addr changes between edges do not affect code.
- Hold:
  - On a rising edge with rst=0 and en=0: code holds its previous value; code_vld <= 0.
- Back-to-back enabled reads produce one new word per cycle, with no bubbles.
- Every 5-bit address is legal; there is no error or out-of-range flag.
- The lookup is a pure constant function of addr and must synthesise as ROM/LUT with no initialisation file dependency.
- code and code_vld are driven only from flops; no combinational path from addr or en to outputs.
- X/Z on addr while en=0 must not disturb outputs.

Test Plan:
- Reset: assert rst 2 cycles with en=1, addr=5 -> code=00, code_vld=0 throughout and the cycle after release until the first enabled read.
- Full sweep: en=1, addr stepped 0..15, one per cycle -> one cycle later code = 10,21,32,...,FE,0F in order; code_vld=1 continuously.
- Upper region: en=1, addr=16,23,31 -> code=00 each, code_vld=1.
- Hold: read addr=3 (code=43), then en=0 while addr changes to 9 -> code stays 43, code_vld drops to 0 the next cycle.
- Reset mid-stream: sweeping with en=1, assert rst for one cycle at addr=7 -> next cycle code=00, code_vld=0; reads then resume with correct data for the current addr.
- Latency check: change addr mid-cycle (between edges) from 2 to 12 -> code updates only at the next rising edge, to DC.

Source files
------------

// File: rtl/code_rom_if.sv
// code_rom_if: fetch-to-ROM read bus.
//   en       - read enable, driven by fetch logic
//   addr     - word address, driven by fetch logic
//   code     - registered code byte, driven by the ROM
//   code_vld - code holds data from an enabled read, driven by the ROM
// master = fetch side, slave = ROM side.
interface code_rom_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic              en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] code;
   logic              code_vld;

   modport master (output en, output addr, input code, input code_vld);
   modport slave  (input en, input addr, output code, output code_vld);
endinterface

// File: rtl/code_rom.sv
// code_rom: 32 x 8 read-only program store for the TMD4 core.
// Contents are a constant lookup; read has exactly one clock of latency.
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (priority over en)
//   bus      - slave side of code_rom_if (en, addr in; code, code_vld out)
// Entries 0..15 hold {(n+1) mod 16, n}; entries 16..31 return FILL.
module code_rom #(
   parameter int                ADDR_W = 5,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL   = '0
) (
   input  logic       clk,
   input  logic       rst,
   code_rom_if.slave  bus
);

   // Entry 0 sits in the least-significant byte.
   localparam logic [15:0][7:0] TAB = {
      8'h0F, 8'hFE, 8'hED, 8'hDC,
      8'hCB, 8'hBA, 8'hA9, 8'h98,
      8'h87, 8'h76, 8'h65, 8'h54,
      8'h43, 8'h32, 8'h21, 8'h10
   };

   logic [DATA_W-1:0] code_q, code_d;
   logic              code_vld_q, code_vld_d;
   logic [DATA_W-1:0] rom_word;

   always_comb begin
      rom_word = FILL;
      if (bus.addr < ADDR_W'(16))
         rom_word = DATA_W'(TAB[bus.addr[3:0]]);
   end

   // With en low the lookup result is ignored entirely, so an unknown
   // addr cannot reach the outputs.
   always_comb begin
      code_d     = code_q;
      code_vld_d = 1'b0;
      if (bus.en) begin
         code_d     = rom_word;
         code_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q     <= '0;
         code_vld_q <= 1'b0;
      end else begin
         code_q     <= code_d;
         code_vld_q <= code_vld_d;
      end
   end

   assign bus.code     = code_q;
   assign bus.code_vld = code_vld_q;

endmodule

// File: tb/tb_code_rom.sv
module tb_code_rom;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] exp_code = 8'h00;
   logic       exp_vld  = 1'b0;

   code_rom_if #(.ADDR_W(5), .DATA_W(8)) bus ();

   code_rom dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Contents from the rule: low nibble n, high nibble n+1 mod 16; upper half 00.
   function automatic logic [7:0] rom_ref(input int n);
      if (n >= 16) return 8'h00;
      return 8'(((((n + 1) % 16) * 16) + n));
   endfunction

   // Advance one edge and update the expected outputs from what was applied.
   task automatic cyc();
      logic r, e;
      logic [4:0] a;
      r = rst; e = bus.en; a = bus.addr;
      @(posedge clk);
      #1;
      if (r) begin
         exp_code = 8'h00; exp_vld = 1'b0;
      end else if (e) begin
         exp_code = rom_ref(int'(a)); exp_vld = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.en = 1'b1; bus.addr = 5'd5;
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++;
         if (bus.code !== 8'h00 || bus.code_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset cyc%0d: got code=%h vld=%b want 00/0", i, bus.code, bus.code_vld);
         end
      end
      rst = 1'b0; bus.en = 1'b0;
      cyc();
      total++;
      if (bus.code !== 8'h00 || bus.code_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got code=%h vld=%b want 00/0", bus.code, bus.code_vld);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] lit [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                               8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};
      bus.en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.addr = 5'(i);
         cyc();
         total++;
         if (bus.code !== lit[i] || bus.code_vld !== 1'b1) begin
            bad++;
            $display("FAIL sweep addr%0d: got code=%h vld=%b want %h/1", i, bus.code, bus.code_vld, lit[i]);
         end
      end
   endtask

   task automatic test_upper();
      int al [3] = '{16, 23, 31};
      bus.en = 1'b1;
      foreach (al[k]) begin
         bus.addr = 5'(al[k]);
         cyc();
         total++;
         if (bus.code !== 8'h00 || bus.code_vld !== 1'b1) begin
            bad++;
            $display("FAIL upper addr%0d: got code=%h vld=%b want 00/1", al[k], bus.code, bus.code_vld);
         end
      end
   endtask

   task automatic test_hold();
      bus.en = 1'b1; bus.addr = 5'd3;
      cyc();
      total++;
      if (bus.code !== 8'h43 || bus.code_vld !== 1'b1) begin
         bad++;
         $display("FAIL hold_read: got code=%h vld=%b want 43/1", bus.code, bus.code_vld);
      end
      bus.en = 1'b0; bus.addr = 5'd9;
      cyc();
      total++;
      if (bus.code !== 8'h43 || bus.code_vld !== 1'b0) begin
         bad++;
         $display("FAIL hold_en0: got code=%h vld=%b want 43/0", bus.code, bus.code_vld);
      end
      bus.addr = 5'bx1z0x;
      cyc();
      total++;
      if (bus.code !== 8'h43 || bus.code_vld !== 1'b0) begin
         bad++;
         $display("FAIL hold_xaddr: got code=%h vld=%b want 43/0", bus.code, bus.code_vld);
      end
   endtask

   task automatic test_midreset();
      bus.en = 1'b1;
      for (int i = 4; i < 11; i++) begin
         bus.addr = 5'(i);
         rst = (i == 7);
         cyc();
         total++;
         if (bus.code !== exp_code || bus.code_vld !== exp_vld) begin
            bad++;
            $display("FAIL midreset addr%0d: got code=%h vld=%b want %h/%b", i, bus.code, bus.code_vld, exp_code, exp_vld);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      bus.en = 1'b1; bus.addr = 5'd2;
      cyc();
      #3;
      bus.addr = 5'd12;
      #1;
      total++;
      if (bus.code !== 8'h32 || bus.code_vld !== 1'b1) begin
         bad++;
         $display("FAIL latency_mid: got code=%h vld=%b want 32/1", bus.code, bus.code_vld);
      end
      cyc();
      total++;
      if (bus.code !== 8'hDC || bus.code_vld !== 1'b1) begin
         bad++;
         $display("FAIL latency_edge: got code=%h vld=%b want DC/1", bus.code, bus.code_vld);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst      = ($urandom_range(0, 19) == 0);
         bus.en   = $urandom_range(0, 3) != 0;
         bus.addr = 5'($urandom_range(0, 31));
         cyc();
         total++;
         if (bus.code !== exp_code || bus.code_vld !== exp_vld) begin
            bad++;
            $display("FAIL random i%0d: got code=%h vld=%b want %h/%b", i, bus.code, bus.code_vld, exp_code, exp_vld);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus.en = 1'b0; bus.addr = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_sweep();
      test_upper();
      test_hold();
      test_midreset();
      test_latency();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
